// File: rtl/mul_seq_n_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encodings and default width.
package mul_seq_n_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/add_n.sv
// N-bit ripple-carry adder from 2-input gates; carry out of the top bit is dropped (mod 2^N).
module add_n #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  wire [N-1:0] p;
  wire [N-1:0] g;
  wire [N-1:0] pc;
  wire [N-1:0] c;
  wire [N-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    xor u_p (p[i], a[i], b[i]);
    xor u_s (s[i], p[i], c[i]);
    // The last stage needs no carry out.
    if (i < N - 1) begin : g_carry
      and u_g  (g[i],  a[i], b[i]);
      and u_pc (pc[i], p[i], c[i]);
      or  u_c  (c[i+1], g[i], pc[i]);
    end else begin : g_top
      assign g[i]  = 1'b0;
      assign pc[i] = 1'b0;
    end
  end

  assign sum = s;

endmodule

// File: rtl/mul_seq_n.sv
// Iterative shift-add multiplier with start/done handshake; one multiplier bit per EXEC cycle,
// optionally stopping early once the remaining multiplier bits are all zero.
module mul_seq_n
  import mul_seq_n_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               op_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_r;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] result_r;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplr_nxt;
  logic               last;

  add_n #(.N(2*WIDTH)) u_add (
    .a   (result_r),
    .b   (mcand_r),
    .sum (sum)
  );

  assign mplr_nxt = mplr_r >> 1;
  assign last     = (cnt_r == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplr_nxt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    if (op_clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  if (op_start) state_nxt = S_EXEC;
        S_EXEC:  if (last)     state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= '0;
      mplr_r   <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else if (op_clear) begin
      mcand_r  <= '0;
      mplr_r   <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (op_start) begin
            mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
            mplr_r   <= multiplier;
            cnt_r    <= '0;
            result_r <= '0;
          end
        end
        S_EXEC: begin
          if (mplr_r[0]) result_r <= sum;
          mcand_r <= mcand_r << 1;
          mplr_r  <= mplr_nxt;
          cnt_r   <= cnt_r + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result  = result_r;
  assign busy    = (state_r != S_IDLE);
  assign op_done = (state_r == S_DONE);

endmodule

// File: tb/tb_mul_seq_n.sv
// Directed bench for mul_seq_n: one instance without and one with early exit, driven in parallel.
module tb_mul_seq_n;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] result0, result1;
  logic        busy0, busy1;
  logic        done0, done1;

  int n_chk  = 0;
  int n_pass = 0;
  int ex0, ex1, nd0, nd1, d0_at, d1_at;

  mul_seq_n #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result0), .busy(busy0), .op_done(done0)
  );

  mul_seq_n #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result1), .busy(busy1), .op_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  // Issues a start at the next negedge and watches both instances for 20 cycles.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    ex0 = 0; ex1 = 0; nd0 = 0; nd1 = 0; d0_at = 0; d1_at = 0;
    @(negedge clk);
    op_start = 1'b1; multiplicand = a; multiplier = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      op_start = 1'b0; multiplicand = 8'hA5; multiplier = 8'h5A;
      if (i == 1) chk("busy_rise", {31'd0, busy0}, 32'd1);
      if (busy0 && !done0) ex0++;
      if (busy1 && !done1) ex1++;
      if (done0) begin nd0++; if (d0_at == 0) d0_at = i; end
      if (done1) begin nd1++; if (d1_at == 0) d1_at = i; end
    end
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_result0", {16'd0, result0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy1", {31'd0, busy1}, 32'd0);

    do_op(8'd13, 8'd11);
    chk("13x11_ex0", ex0, 8);
    chk("13x11_done_at0", d0_at, 9);
    chk("13x11_pulses0", nd0, 1);
    chk("13x11_res0", {16'd0, result0}, 32'd143);
    chk("13x11_ex1", ex1, 4);
    chk("13x11_res1", {16'd0, result1}, 32'd143);
    repeat (3) @(negedge clk);
    chk("13x11_hold0", {16'd0, result0}, 32'd143);

    do_op(8'd255, 8'd255);
    chk("255x255_res0", {16'd0, result0}, 32'h0000FE01);
    chk("255x255_done_at0", d0_at, 9);
    chk("255x255_ex1", ex1, 8);
    chk("255x255_res1", {16'd0, result1}, 32'd65025);

    do_op(8'd0, 8'h77);
    chk("0x77_res0", {16'd0, result0}, 32'd0);
    chk("0x77_ex0", ex0, 8);
    chk("0x77_ex1", ex1, 7);

    do_op(8'd200, 8'd5);
    chk("200x5_ex1", ex1, 3);
    chk("200x5_res1", {16'd0, result1}, 32'd1000);
    chk("200x5_res0", {16'd0, result0}, 32'd1000);

    do_op(8'd7, 8'd0);
    chk("7x0_ex1", ex1, 1);
    chk("7x0_res1", {16'd0, result1}, 32'd0);
    chk("7x0_ex0", ex0, 8);

    do_op(8'd1, 8'd128);
    chk("1x128_ex1", ex1, 8);
    chk("1x128_res1", {16'd0, result1}, 32'd128);

    // Starts while busy (EXEC, then DONE) must be ignored.
    @(negedge clk);
    op_start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(negedge clk);
    op_start = 1'b0;
    @(negedge clk);
    op_start = 1'b1; multiplicand = 8'd3; multiplier = 8'd3;
    @(negedge clk);
    op_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("9x9_done_seen", seen, 1);
    op_start = 1'b1; multiplicand = 8'd3; multiplier = 8'd3;
    @(negedge clk);
    op_start = 1'b0;
    chk("start_in_done_busy0", {31'd0, busy0}, 32'd0);
    chk("9x9_res0", {16'd0, result0}, 32'd81);
    repeat (12) @(negedge clk);

    // Clear during EXEC.
    op_start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
    @(negedge clk);
    op_start = 1'b0;
    repeat (2) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clr_busy0", {31'd0, busy0}, 32'd0);
    chk("clr_busy1", {31'd0, busy1}, 32'd0);
    chk("clr_res0", {16'd0, result0}, 32'd0);
    chk("clr_res1", {16'd0, result1}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy0) seen++;
    end
    chk("clr_no_done", seen, 0);
    op_start = 1'b1; op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0; op_clear = 1'b0;
    chk("start_clr_busy0", {31'd0, busy0}, 32'd0);
    chk("start_clr_busy1", {31'd0, busy1}, 32'd0);

    // Asynchronous reset mid-EXEC.
    @(negedge clk);
    op_start = 1'b1; multiplicand = 8'd50; multiplier = 8'd60;
    @(negedge clk);
    op_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("50x60_partial0", {16'd0, result0}, 32'd200);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_res0", {16'd0, result0}, 32'd0);
    chk("arst_busy0", {31'd0, busy0}, 32'd0);
    chk("arst_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 || done1) seen++;
    end
    chk("arst_no_done", seen, 0);

    do_op(8'd6, 8'd7);
    chk("6x7_res0", {16'd0, result0}, 32'd42);
    chk("6x7_res1", {16'd0, result1}, 32'd42);
    chk("6x7_ex1", ex1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
